// File: rtl/axi4_mem_responder.sv
// AXI4 slave terminating one port on an internal byte-addressable RAM.
// One outstanding write and one outstanding read; FIXED, INCR and WRAP bursts.
module axi4_mem_responder #(
    parameter int N     = 4,
    parameter int I     = 4,
    parameter int DEPTH = 256
) (
    input  logic           aclk,
    input  logic           areset,
    input  logic [I-1:0]   awid,
    input  logic [31:0]    awaddr,
    input  logic [7:0]     awlen,
    input  logic [2:0]     awsize,
    input  logic [1:0]     awburst,
    input  logic           awvalid,
    output logic           awready,
    input  logic [8*N-1:0] wdata,
    input  logic [N-1:0]   wstrb,
    input  logic           wlast,
    input  logic           wvalid,
    output logic           wready,
    output logic [I-1:0]   bid,
    output logic [1:0]     bresp,
    output logic           bvalid,
    input  logic           bready,
    input  logic [I-1:0]   arid,
    input  logic [31:0]    araddr,
    input  logic [7:0]     arlen,
    input  logic [2:0]     arsize,
    input  logic [1:0]     arburst,
    input  logic           arvalid,
    output logic           arready,
    output logic [I-1:0]   rid,
    output logic [8*N-1:0] rdata,
    output logic [1:0]     rresp,
    output logic           rlast,
    output logic           rvalid,
    input  logic           rready
);
    localparam int SZ = $clog2(N);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] STEP  = 32'(N);
    localparam logic [31:0] ALIGN = ~(STEP - 32'd1);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;
    typedef enum logic [1:0] {M_FIXED, M_INCR, M_WRAP} mode_t;

    logic [8*N-1:0] mem [DEPTH];

    function automatic logic bad_burst(input logic [1:0] b,
                                       input logic [2:0] s,
                                       input logic [7:0] l);
        logic wrap_ok;
        wrap_ok = (l == 8'd1) || (l == 8'd3) || (l == 8'd7) || (l == 8'd15);
        return (b == 2'b11) || (s != 3'(SZ)) || ((b == 2'b10) && !wrap_ok);
    endfunction

    // Malformed bursts still walk the address space as INCR.
    function automatic mode_t mode_of(input logic [1:0] b,
                                      input logic [2:0] s,
                                      input logic [7:0] l);
        if (bad_burst(b, s, l)) return M_INCR;
        if (b == 2'b00) return M_FIXED;
        if (b == 2'b10) return M_WRAP;
        return M_INCR;
    endfunction

    function automatic logic [31:0] next_addr(input logic [31:0] a,
                                              input mode_t m,
                                              input logic [7:0] l);
        logic [31:0] mask;
        mask = ((32'(l) + 32'd1) << SZ) - 32'd1;
        case (m)
            M_FIXED: return a;
            M_WRAP:  return (a & ~mask) | ((a + STEP) & mask);
            default: return a + STEP;
        endcase
    endfunction

    function automatic logic in_range(input logic [31:0] a);
        return (a >> SZ) < 32'(DEPTH);
    endfunction

    function automatic logic [AW-1:0] word(input logic [31:0] a);
        logic [31:0] w;
        w = a >> SZ;
        return w[AW-1:0];
    endfunction

    wstate_t ws, ws_n;
    rstate_t rs, rs_n;
    logic live;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            ws   <= W_IDLE;
            rs   <= R_IDLE;
            live <= 1'b0;
        end else begin
            ws   <= ws_n;
            rs   <= rs_n;
            live <= 1'b1;
        end
    end

    logic [I-1:0] wid;
    logic [31:0]  waddr;
    logic [7:0]   wlen, wcnt;
    mode_t        wmode;
    logic         werr, wdrop;

    always_comb begin
        ws_n    = ws;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        case (ws)
            W_IDLE: begin
                awready = live;
                if (awvalid && live) ws_n = W_DATA;
            end
            W_DATA: begin
                wready = 1'b1;
                if (wvalid && (wcnt == wlen)) ws_n = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) ws_n = W_IDLE;
            end
            default: ws_n = W_IDLE;
        endcase
    end

    logic aw_hs, w_hs;
    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign bid   = wid;
    assign bresp = {werr, 1'b0};

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wid   <= '0;
            waddr <= '0;
            wlen  <= '0;
            wcnt  <= '0;
            wmode <= M_INCR;
            werr  <= 1'b0;
            wdrop <= 1'b0;
        end else if (aw_hs) begin
            wid   <= awid;
            waddr <= awaddr & ALIGN;
            wlen  <= awlen;
            wcnt  <= '0;
            wmode <= mode_of(awburst, awsize, awlen);
            werr  <= bad_burst(awburst, awsize, awlen);
            wdrop <= (awburst == 2'b11);
        end else if (w_hs) begin
            waddr <= next_addr(waddr, wmode, wlen);
            wcnt  <= wcnt + 8'd1;
            if (!in_range(waddr) || (wlast != (wcnt == wlen)))
                werr <= 1'b1;
        end
    end

    // RAM is deliberately outside reset so contents survive it.
    always_ff @(posedge aclk) begin
        if (w_hs && !wdrop && in_range(waddr)) begin
            for (int b = 0; b < N; b++)
                if (wstrb[b]) mem[word(waddr)][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

    logic [31:0] raddr, raddr_n;
    logic [7:0]  rlen, rcnt;
    mode_t       rmode;
    logic        rberr, rerr_n, rlast_n, rload;
    logic        ar_hs, r_hs;

    always_comb begin
        rs_n    = rs;
        arready = 1'b0;
        rvalid  = 1'b0;
        case (rs)
            R_IDLE: begin
                arready = live;
                if (arvalid && live) rs_n = R_DATA;
            end
            R_DATA: begin
                rvalid = 1'b1;
                if (rready && rlast) rs_n = R_IDLE;
            end
            default: rs_n = R_IDLE;
        endcase
    end

    assign ar_hs = arvalid && arready;
    assign r_hs  = rvalid && rready;

    always_comb begin
        rload   = 1'b0;
        raddr_n = raddr;
        rlast_n = 1'b0;
        rerr_n  = rberr;
        if (ar_hs) begin
            rload   = 1'b1;
            raddr_n = araddr & ALIGN;
            rlast_n = (arlen == 8'd0);
            rerr_n  = bad_burst(arburst, arsize, arlen);
        end else if (r_hs && !rlast) begin
            rload   = 1'b1;
            raddr_n = next_addr(raddr, rmode, rlen);
            rlast_n = ((rcnt + 8'd1) == rlen);
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rid   <= '0;
            rdata <= '0;
            rresp <= '0;
            rlast <= 1'b0;
            raddr <= '0;
            rlen  <= '0;
            rcnt  <= '0;
            rmode <= M_INCR;
            rberr <= 1'b0;
        end else begin
            if (ar_hs) begin
                rid   <= arid;
                rlen  <= arlen;
                rcnt  <= '0;
                rmode <= mode_of(arburst, arsize, arlen);
                rberr <= rerr_n;
            end else if (rload) begin
                rcnt <= rcnt + 8'd1;
            end
            if (rload) begin
                raddr <= raddr_n;
                rlast <= rlast_n;
                rdata <= in_range(raddr_n) ? mem[word(raddr_n)] : '0;
                rresp <= (rerr_n || !in_range(raddr_n)) ? 2'b10 : 2'b00;
            end
        end
    end
endmodule

// File: tb/tb_axi4_mem_responder.sv
// Scoreboard bench for axi4_mem_responder: stimulus queues expected B/R
// responses, a negedge monitor pops and compares them on each handshake.
module tb_axi4_mem_responder;
    logic        aclk = 1'b0;
    logic        areset;
    logic [3:0]  awid, arid, bid, rid;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wlast, wvalid, wready;
    logic        bvalid, bready, arvalid, arready;
    logic        rlast, rvalid, rready;

    int ntests = 0;
    int nfail  = 0;
    logic [63:0] bq[$];
    logic [63:0] rq[$];
    logic        rtog = 1'b0;

    axi4_mem_responder #(.N(4), .I(4), .DEPTH(256)) dut (
        .aclk(aclk), .areset(areset),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] rexp(input logic [3:0] id,
                                         input logic [31:0] d,
                                         input logic [1:0] rsp,
                                         input logic lst);
        return 64'({id, d, rsp, lst});
    endfunction

    function automatic logic [63:0] bexp(input logic [3:0] id,
                                         input logic [1:0] rsp);
        return 64'({id, rsp});
    endfunction

    initial begin
        logic [63:0] held;
        logic        hold;
        logic [63:0] e;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge aclk);
            if (areset) begin
                hold = 1'b0;
            end else begin
                if (bvalid && bready) begin
                    if (bq.size() == 0) chk("b_unexpected", 64'd1, 64'd0);
                    else begin
                        e = bq.pop_front();
                        chk("b_resp", 64'({bid, bresp}), e);
                    end
                end
                if (rvalid && rready) begin
                    if (rq.size() == 0) chk("r_unexpected", 64'd1, 64'd0);
                    else begin
                        e = rq.pop_front();
                        chk("r_beat", 64'({rid, rdata, rresp, rlast}), e);
                    end
                end
                if (hold && rvalid)
                    chk("r_stable", 64'({rid, rdata, rresp, rlast}), held);
                hold = rvalid && !rready;
                held = 64'({rid, rdata, rresp, rlast});
            end
        end
    end

    initial begin
        forever begin
            @(posedge aclk);
            #1;
            if (rtog) rready = !rready;
        end
    end

    task automatic send_aw(input logic [3:0] id, input logic [31:0] a,
                           input logic [7:0] l, input logic [1:0] b);
        logic ok;
        awid = id; awaddr = a; awlen = l; awburst = b; awsize = 3'd2;
        awvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge aclk);
            if (awready) ok = 1'b1;
        end
        chk("aw_accept", 64'(ok), 64'd1);
        @(posedge aclk);
        #1;
        awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s,
                          input logic l);
        logic ok;
        wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge aclk);
            if (wready) ok = 1'b1;
        end
        chk("w_accept", 64'(ok), 64'd1);
        @(posedge aclk);
        #1;
        wvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [31:0] a,
                           input logic [7:0] l, input logic [1:0] b);
        logic ok;
        arid = id; araddr = a; arlen = l; arburst = b; arsize = 3'd2;
        arvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge aclk);
            if (arready) ok = 1'b1;
        end
        chk("ar_accept", 64'(ok), 64'd1);
        @(posedge aclk);
        #1;
        arvalid = 1'b0;
    endtask

    task automatic wait_b();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(posedge aclk);
            #1;
            if (bq.size() == 0) ok = 1'b1;
        end
        chk("b_done", 64'(ok), 64'd1);
    endtask

    task automatic wait_r();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(posedge aclk);
            #1;
            if (rq.size() == 0) ok = 1'b1;
        end
        chk("r_done", 64'(ok), 64'd1);
    endtask

    task automatic wr1(input logic [3:0] id, input logic [31:0] a,
                       input logic [31:0] d, input logic [1:0] rsp);
        bq.push_back(bexp(id, rsp));
        send_aw(id, a, 8'd0, 2'b01);
        send_w(d, 4'hF, 1'b1);
        wait_b();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        areset = 1'b1;
        awid = '0; awaddr = '0; awlen = '0; awsize = 3'd2; awburst = 2'b01;
        awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
        bready = 1'b1;
        arid = '0; araddr = '0; arlen = '0; arsize = 3'd2; arburst = 2'b01;
        arvalid = 1'b0;
        rready = 1'b1;

        repeat (3) @(posedge aclk);
        #1;
        chk("reset_outs", 64'({awready, wready, bvalid, arready, rvalid,
            rlast, bresp, rresp, bid, rid, rdata}), 64'd0);
        areset = 1'b0;
        @(negedge aclk);
        chk("ready_pre_edge", 64'({awready, arready}), 64'd0);
        @(posedge aclk);
        #1;
        chk("ready_post_edge", 64'({awready, arready}), 64'b11);

        // Single-beat write and readback
        bq.push_back(bexp(4'd3, 2'b00));
        send_aw(4'd3, 32'h10, 8'd0, 2'b01);
        chk("aw_to_w", 64'({wready, awready}), 64'b10);
        send_w(32'hDEADBEEF, 4'hF, 1'b1);
        chk("w_to_b", 64'({bvalid, wready}), 64'b10);
        wait_b();
        chk("b_to_aw", 64'({awready, bvalid}), 64'b10);
        rq.push_back(rexp(4'd5, 32'hDEADBEEF, 2'b00, 1'b1));
        send_ar(4'd5, 32'h10, 8'd0, 2'b01);
        chk("ar_to_r", 64'({rvalid, arready}), 64'b10);
        wait_r();

        // INCR burst with strobes, read back with RREADY toggling
        wr1(4'd1, 32'h28, 32'hFFFFFFFF, 2'b00);
        bq.push_back(bexp(4'd2, 2'b00));
        send_aw(4'd2, 32'h20, 8'd3, 2'b01);
        send_w(32'd1, 4'hF, 1'b0);
        send_w(32'd2, 4'hF, 1'b0);
        send_w(32'd3, 4'h3, 1'b0);
        send_w(32'd4, 4'hF, 1'b1);
        wait_b();
        rq.push_back(rexp(4'd6, 32'd1, 2'b00, 1'b0));
        rq.push_back(rexp(4'd6, 32'd2, 2'b00, 1'b0));
        rq.push_back(rexp(4'd6, 32'hFFFF0003, 2'b00, 1'b0));
        rq.push_back(rexp(4'd6, 32'd4, 2'b00, 1'b1));
        rtog = 1'b1;
        send_ar(4'd6, 32'h20, 8'd3, 2'b01);
        wait_r();
        rtog = 1'b0;
        rready = 1'b1;

        // WRAP write, INCR readback
        bq.push_back(bexp(4'd7, 2'b00));
        send_aw(4'd7, 32'h38, 8'd3, 2'b10);
        send_w(32'hAAAA000A, 4'hF, 1'b0);
        send_w(32'hBBBB000B, 4'hF, 1'b0);
        send_w(32'hCCCC000C, 4'hF, 1'b0);
        send_w(32'hDDDD000D, 4'hF, 1'b1);
        wait_b();
        rq.push_back(rexp(4'd8, 32'hCCCC000C, 2'b00, 1'b0));
        rq.push_back(rexp(4'd8, 32'hDDDD000D, 2'b00, 1'b0));
        rq.push_back(rexp(4'd8, 32'hAAAA000A, 2'b00, 1'b0));
        rq.push_back(rexp(4'd8, 32'hBBBB000B, 2'b00, 1'b1));
        send_ar(4'd8, 32'h30, 8'd3, 2'b01);
        wait_r();

        // Range errors
        wr1(4'd1, 32'h0, 32'hCAFE0000, 2'b00);
        wr1(4'd1, 32'h3FC, 32'h12345678, 2'b00);
        wr1(4'd9, 32'h400, 32'hFFFFFFFF, 2'b10);
        rq.push_back(rexp(4'd10, 32'hCAFE0000, 2'b00, 1'b1));
        send_ar(4'd10, 32'h0, 8'd0, 2'b01);
        wait_r();
        rq.push_back(rexp(4'd11, 32'h12345678, 2'b00, 1'b0));
        rq.push_back(rexp(4'd11, 32'h0, 2'b10, 1'b1));
        send_ar(4'd11, 32'h3FC, 8'd1, 2'b01);
        wait_r();

        // Early WLAST and B backpressure
        bq.push_back(bexp(4'hC, 2'b10));
        send_aw(4'hC, 32'h50, 8'd2, 2'b01);
        send_w(32'h50, 4'hF, 1'b0);
        send_w(32'h51, 4'hF, 1'b1);
        bready = 1'b0;
        send_w(32'h52, 4'hF, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            chk("b_hold", 64'({bvalid, awready}), 64'b10);
        end
        @(posedge aclk);
        #1;
        bready = 1'b1;
        wait_b();
        chk("b_release", 64'({awready, bvalid}), 64'b10);
        rq.push_back(rexp(4'd4, 32'h50, 2'b00, 1'b0));
        rq.push_back(rexp(4'd4, 32'h51, 2'b00, 1'b0));
        rq.push_back(rexp(4'd4, 32'h52, 2'b00, 1'b1));
        send_ar(4'd4, 32'h50, 8'd2, 2'b01);
        wait_r();

        // Reset in the middle of a long read
        bq.push_back(bexp(4'd1, 2'b00));
        send_aw(4'd1, 32'h80, 8'd7, 2'b01);
        for (int i = 0; i < 8; i++)
            send_w(32'h8000 + 32'(i), 4'hF, i == 7);
        wait_b();
        for (int i = 0; i < 8; i++)
            rq.push_back(rexp(4'd2, 32'h8000 + 32'(i), 2'b00, i == 7));
        send_ar(4'd2, 32'h80, 8'd7, 2'b01);
        @(posedge aclk);
        #1;
        @(posedge aclk);
        #1;
        areset = 1'b1;
        rq.delete();
        #1;
        chk("reset_abort", 64'({rvalid, arready, awready}), 64'd0);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        @(negedge aclk);
        chk("arready_pre_edge", 64'(arready), 64'd0);
        @(posedge aclk);
        #1;
        chk("ready_after_abort", 64'({arready, awready}), 64'b11);
        for (int i = 0; i < 8; i++)
            rq.push_back(rexp(4'd3, 32'h8000 + 32'(i), 2'b00, i == 7));
        send_ar(4'd3, 32'h80, 8'd7, 2'b01);
        wait_r();

        repeat (3) @(posedge aclk);
        chk("queues_empty", 64'(bq.size() + rq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule

// File: doc/axi4_mem_responder.md
# axi4_mem_responder

Synthesizable AXI4 slave that terminates one AXI4 port with an internal byte-addressable RAM. It supports FIXED, INCR and WRAP bursts and handles one outstanding write and one outstanding read, each with its own state machine. Its job is to give the AXI4 master bus-functional model a real, cycle-accurate responder, so traffic can be driven at the RTL level without a behavioural slave.

## Interface
- N, 4, data bytes per beat (power of 2, 1..64); data buses are 8*N bits wide
- I, 4, ID width
- DEPTH, 256, memory depth in N-byte words; valid byte addresses are 0 .. DEPTH*N-1
- ACLK  in  1  clock; all logic is on the rising edge
- ARESET  in  1  reset: one clock, asynchronous, active-high
- AWID, ARID  in  I  request IDs
- AWADDR, ARADDR  in  32  byte addresses; the low log2(N) bits are ignored (address is aligned down)
- AWLEN, ARLEN  in  8  beats minus 1
- AWSIZE, ARSIZE  in  3  must equal log2(N)
- AWBURST, ARBURST  in  2  burst type: 00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- AWVALID, ARVALID, WVALID, BREADY, RREADY  in  1  handshakes driven by the master
- AWREADY, ARREADY, WREADY, BVALID, RVALID  out  1  handshakes driven by this block
- WDATA  in  8*N  write data
- WSTRB  in  N  byte enables
- WLAST  in  1  last write beat
- BID, RID  out  I  response IDs, echoed from the accepted request
- BRESP, RRESP  out  2  responses: 00 OKAY, 10 SLVERR
- RDATA  out  8*N  read data
- RLAST  out  1  last read beat
- There are no REGION, LOCK, CACHE, PROT or QOS ports; those fields are don't-care to this block.

## Operation
- **Write FSM states:** W_IDLE, W_DATA, W_RESP.
  - W_IDLE: AWREADY=1. An AW handshake latches id, address, len, burst and an error flag, then moves to W_DATA.
  - W_DATA: WREADY=1. Each W handshake writes every byte whose WSTRB bit is set to the current word, then advances the address and the beat counter. The beat that matches len moves to W_RESP. Beat counting is driven by len only; WLAST does not end the burst.
  - W_RESP: BVALID=1, BID=latched id. A B handshake returns to W_IDLE.
- **Write errors:** BRESP=SLVERR if any of the following occurs, otherwise OKAY:
  - burst type is 11;
  - AWSIZE ≠ log2(N);
  - WRAP with len not in {1,3,7,15};
  - WLAST is not asserted on the last beat, or is asserted on any earlier beat;
  - any beat falls out of range.
- Out-of-range beats and bursts with burst type 11 write nothing. A WRAP burst with a bad len, and any burst with a bad size, still writes as INCR with a stride of N.
- **Read FSM states:** R_IDLE, R_DATA.
  - R_IDLE: ARREADY=1. An AR handshake latches the request and loads beat 0 into the R registers.
  - R_DATA: RVALID=1. On RVALID&&RREADY the next beat is loaded. On the beat that matches len, RLAST=1; its handshake returns to R_IDLE.
- **Read errors:** reported per beat. An out-of-range beat returns RDATA=0 and RRESP=SLVERR. A burst-level error (type 11, bad size, bad WRAP len) gives SLVERR on every beat; the addresses for such a burst follow the same rules as writes.
- **Address rules:**
  - FIXED: address unchanged.
  - INCR: address + N.
  - WRAP: container size = (len+1)*N, aligned to itself; the address wraps to the container base at the upper boundary.
  - Range is checked on the word index (addr >> log2(N)) against DEPTH, after alignment.
- The memory is never reset. Contents survive ARESET.

## Timing
- **Reset values, applied asynchronously:** every output is 0, including AWREADY and ARREADY. AWREADY and ARREADY go to 1 on the first ACLK edge after ARESET falls.
- **Reset mid-burst:** both FSMs abort to idle immediately and any in-flight burst is dropped.
- **Write timing:**
  - AW handshake at edge k gives WREADY=1 from edge k; AWREADY=0 at the same time.
  - W beats are accepted back-to-back.
  - Last W handshake at edge m gives BVALID=1 from edge m.
  - B handshake at edge p gives AWREADY=1 from edge p.
- **Read timing:**
  - AR handshake at edge k gives RVALID=1 from edge k, with beat 0 valid.
  - R beats run back-to-back at full throughput.
  - While RVALID&&!RREADY, RDATA, RID, RRESP and RLAST hold stable.
  - Last R handshake at edge p gives ARREADY=1 from edge p.
- VALID outputs never deassert without a handshake, except under ARESET.
- **Read/write to the same word at the same edge:** the R register loads the old data. The write is visible to any beat loaded at a later edge.
- The read and write channels are fully independent and may be active in the same cycle.

## Test plan
All scenarios use N=4, I=4, DEPTH=256.

1. **Single-beat write and readback:** AW id=3, addr 0x10, len 0, INCR; W 0xDEADBEEF, strb 0xF, WLAST=1 -> BID=3, BRESP=00. AR id=5, addr 0x10, len 0 -> RID=5, RDATA=0xDEADBEEF, RLAST=1, RRESP=00.
2. **INCR burst with strobes and RREADY toggling:** write addr 0x20, len 3, data 1,2,3,4, with strb 0x3 on beat 2 over a prior 0xFFFFFFFF -> BRESP=00. Read back with RREADY toggling every cycle -> 1, 2, 0xFFFF0003, 4; data stable while stalled; RLAST on beat 3 only.
3. **WRAP write:** addr 0x38, len 3, data A,B,C,D -> lands at 0x38, 0x3C, 0x30, 0x34. INCR read 0x30, len 3 -> C, D, A, B.
4. **Range errors:** write addr 0x400 -> BRESP=10 and memory unchanged. Read 0x3FC, len 1 -> beat 0 OKAY with stored data; beat 1 RDATA=0, RRESP=10, RLAST=1.
5. **Protocol error and B backpressure:** len 2 write with WLAST on beat 1 -> 3 beats accepted, BRESP=10. Hold BREADY=0 for 5 cycles -> BVALID stays 1, AWREADY stays 0; AWREADY=1 from the handshake edge.
6. **Reset mid-read:** ARESET during beat 2 of a len 7 read -> RVALID=0 and ARREADY=0 immediately; ARREADY=1 one edge after release. A later readback of the region returns the previously written data.
